// File: rtl/recip_pkg.sv
// recip_pkg: shared defaults, FSM encoding and seed formula for the reciprocal engine
package recip_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int LUT_BITS_DEF = 7;
    localparam int NR_ITERS_DEF = 1;
    localparam logic [DATA_W_DEF-1:0] RECIP_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_SEED,
        S_MUL_T,
        S_MUL_R,
        S_DONE
    } state_e;

    function automatic logic [63:0] seed_calc(input int idx, input int dw, input int lb);
        logic [63:0] q;
        logic [63:0] mx;
        q  = (64'd1 << (dw - 1 + lb)) / (64'(1 << lb) + 64'(idx));
        mx = (64'd1 << (dw - 1)) - 64'd1;
        return (q > mx) ? mx : q;
    endfunction
endpackage

// File: rtl/recip_seed_rom.sv
// recip_seed_rom: combinational reciprocal seed table built at elaboration
module recip_seed_rom import recip_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LUT_BITS = LUT_BITS_DEF
) (
    input  logic [LUT_BITS-1:0] idx_i,
    output logic [DATA_W-1:0]   seed_o
);
    logic [DATA_W-1:0] rom [2**LUT_BITS];

    for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_rom
        localparam logic [63:0] V = seed_calc(g, DATA_W, LUT_BITS);
        assign rom[g] = V[DATA_W-1:0];
    end

    assign seed_o = rom[idx_i];
endmodule

// File: rtl/recip_nr_unit.sv
// recip_nr_unit: normalise, seed from ROM, refine with Newton-Raphson on one shared multiplier
module recip_nr_unit import recip_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LUT_BITS = LUT_BITS_DEF,
    parameter int NR_ITERS = NR_ITERS_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_W-1:0]         i_divisor,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_reciprocal,
    output logic [$clog2(DATA_W)-1:0] o_shift,
    output logic                      o_dz
);
    localparam int SW = $clog2(DATA_W);
    localparam int IW = (NR_ITERS > 1) ? $clog2(NR_ITERS) : 1;
    localparam logic [DATA_W-1:0] RMAX = {1'b0, {(DATA_W-1){1'b1}}};

    state_e              state_q, state_d;
    logic [DATA_W-2:0]   m_q, m_d;
    logic [DATA_W-1:0]   r_q, r_d, e_q, e_d;
    logic [SW-1:0]       shift_q, shift_d, lz;
    logic                dz_q, dz_d;
    logic [IW-1:0]       it_q, it_d;
    logic [DATA_W-1:0]   seed, mul_a, mul_b, t, rr;
    logic [2*DATA_W-1:0] prod;
    logic                unused_ok;

    recip_seed_rom #(.DATA_W(DATA_W), .LUT_BITS(LUT_BITS)) u_rom (
        .idx_i  (m_q[DATA_W-3 -: LUT_BITS]),
        .seed_o (seed)
    );

    // highest set bit wins; an all-zero divisor falls through to the maximum shift
    always_comb begin
        lz = SW'(DATA_W - 2);
        for (int k = 0; k < DATA_W - 1; k++)
            if (m_q[k]) lz = SW'(DATA_W - 2 - k);
    end

    assign mul_a = (state_q == S_MUL_T) ? {1'b0, m_q} : r_q;
    assign mul_b = (state_q == S_MUL_T) ? r_q : e_q;
    assign prod  = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};
    assign t     = prod[2*DATA_W-3:DATA_W-2];
    assign rr    = prod[2*DATA_W-2:DATA_W-1];
    assign unused_ok = ^{prod[2*DATA_W-1], prod[DATA_W-3:0], i_divisor[DATA_W-1]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        e_d     = e_q;
        shift_d = shift_q;
        dz_d    = dz_q;
        it_d    = it_q;
        case (state_q)
            S_IDLE: if (i_valid) begin
                m_d     = i_divisor[DATA_W-2:0];
                state_d = S_NORM;
            end
            S_NORM: begin
                m_d     = m_q << lz;
                shift_d = lz;
                dz_d    = (m_q == '0);
                state_d = S_SEED;
            end
            S_SEED: begin
                r_d     = seed;
                state_d = (NR_ITERS == 0) ? S_DONE : S_MUL_T;
            end
            // t == 0 would give 2^DATA_W, which saturates to all ones
            S_MUL_T: begin
                e_d     = (t == '0) ? '1 : -t;
                state_d = S_MUL_R;
            end
            S_MUL_R: begin
                r_d     = (rr > RMAX) ? RMAX : rr;
                it_d    = (it_q == IW'(NR_ITERS - 1)) ? '0 : it_q + IW'(1);
                state_d = (it_q == IW'(NR_ITERS - 1)) ? S_DONE : S_MUL_T;
            end
            S_DONE: if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            r_q     <= '0;
            e_q     <= '0;
            shift_q <= '0;
            dz_q    <= 1'b0;
            it_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            e_q     <= e_d;
            shift_q <= shift_d;
            dz_q    <= dz_d;
            it_q    <= it_d;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_valid      = (state_q == S_DONE);
    assign o_reciprocal = dz_q ? RMAX : r_q;
    assign o_shift      = shift_q;
    assign o_dz         = dz_q;
endmodule
